rgb_led_pwm_ctrl: RTL and testbench



---
 rtl/rgb_led_pwm_ctrl.sv | 58 +++++
 tb/tb_rgb_led_pwm_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm_ctrl.sv
// rgb_led_pwm_ctrl: shared-counter 8-bit PWM for the RGB LED lines with shadowed duty registers
module rgb_led_pwm_ctrl #(
    parameter int NumChannels = 12,
    parameter int ClkDiv      = 64,
    parameter int AddrWidth   = 4
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_i,
    input  logic                   en_i,
    input  logic                   wr_en_i,
    input  logic [AddrWidth-1:0]   wr_addr_i,
    input  logic [7:0]             wr_data_i,
    output logic [NumChannels-1:0] pwm_o,
    output logic                   period_o
);
    localparam logic [15:0]        PrescMax = 16'(ClkDiv - 1);
    localparam logic [AddrWidth:0] NumCh    = (AddrWidth + 1)'(NumChannels);
    logic [15:0]                        presc_q, presc_d;
    logic [7:0]                         cnt_q, cnt_d;
    logic [NumChannels-1:0][7:0]        shadow_q, shadow_d;
    logic [NumChannels-1:0][7:0]        active_q, active_d;
    logic [NumChannels-1:0]             pwm_q, pwm_d;
    logic                               period_q, period_d;
    logic                               tick, wrap;
    always_comb begin
        tick     = en_i && presc_q == PrescMax;
        wrap     = tick && cnt_q == 8'hFF;
        presc_d  = (!en_i || tick) ? 16'd0 : presc_q + 16'd1;
        cnt_d    = !en_i ? 8'd0 : tick ? cnt_q + 8'd1 : cnt_q;
        period_d = wrap;
        shadow_d = shadow_q;
        if (wr_en_i && {1'b0, wr_addr_i} < NumCh) shadow_d[wr_addr_i] = wr_data_i;
        // While disabled the active set tracks the shadows so re-enable starts with fresh duties
        for (int i = 0; i < NumChannels; i++) begin
            active_d[i] = (!en_i || wrap) ? shadow_q[i] : active_q[i];
            pwm_d[i]    = en_i && (cnt_q < active_q[i]);
        end
    end
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= '0;
            period_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            period_q <= period_d;
        end
    end
    assign pwm_o    = pwm_q;
    assign period_o = period_q;
endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb_rgb_led_pwm_ctrl: directed checks of the RGB LED PWM controller with ClkDiv = 4
module tb_rgb_led_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [11:0] pwm;
    logic        period;
    int          tests = 0;
    int          fails = 0;
    int          cnt_a, cnt_b, seen;
    logic [11:0] acc;

    rgb_led_pwm_ctrl #(.NumChannels(12), .ClkDiv(4), .AddrWidth(4)) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .en_i(en), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .pwm_o(pwm), .period_o(period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        // reset with enable high and no writes
        step(2);
        chk("rst_pwm", 32'(pwm), 32'h0);
        chk("rst_period", 32'(period), 32'h0);
        rst = 1'b0;
        acc = '0; seen = 0;
        for (int i = 0; i < 1023; i++) begin step(1); acc |= pwm; seen += int'(period); end
        chk("idle_pwm", 32'(acc), 32'h0);
        chk("no_early_period", 32'(seen), 32'h0);
        step(1);
        chk("period_first", 32'(period), 32'h1);
        step(1);
        chk("period_one_cycle", 32'(period), 32'h0);
        seen = 0;
        for (int i = 0; i < 1022; i++) begin step(1); seen += int'(period); end
        chk("no_mid_period", 32'(seen), 32'h0);
        step(1);
        chk("period_second", 32'(period), 32'h1);

        // write ch0 while disabled, then re-enable
        en = 1'b0;
        wr(4'd0, 8'd128);
        step(1);
        chk("disabled_pwm", 32'(pwm), 32'h0);
        chk("disabled_period", 32'(period), 32'h0);
        en = 1'b1;
        cnt_a = 0; cnt_b = 0; seen = 0;
        for (int i = 0; i < 512; i++) begin step(1); cnt_a += int'(pwm == 12'h001); seen += int'(period); end
        for (int i = 0; i < 511; i++) begin step(1); cnt_b += int'(pwm == 12'h000); seen += int'(period); end
        step(1);
        cnt_b += int'(pwm == 12'h000);
        chk("ch0_high_512", 32'(cnt_a), 32'd512);
        chk("ch0_low_512", 32'(cnt_b), 32'd512);
        chk("no_reenable_period", 32'(seen), 32'h0);
        chk("ch0_period_end", 32'(period), 32'h1);

        // ch5 = 255, then write 0 mid-period
        en = 1'b0;
        wr(4'd5, 8'd255);
        step(1);
        en = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 1024; i++) begin step(1); cnt_a += int'(!pwm[5]); end
        chk("ch5_low_4", 32'(cnt_a), 32'd4);
        chk("ch5_period", 32'(period), 32'h1);
        step(100);
        wr(4'd5, 8'd0);
        cnt_a = 0;
        for (int i = 0; i < 923; i++) begin step(1); cnt_a += int'(!pwm[5]); end
        chk("ch5_unchanged_low", 32'(cnt_a), 32'd4);
        chk("ch5_load_period", 32'(period), 32'h1);
        cnt_a = 0;
        for (int i = 0; i < 1024; i++) begin step(1); cnt_a += int'(pwm[5]); end
        chk("ch5_zero_high", 32'(cnt_a), 32'd0);

        // ch3 written in the wrap cycle
        en = 1'b0;
        wr(4'd3, 8'h10);
        step(1);
        en = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 1023; i++) begin step(1); cnt_a += int'(pwm[3]); end
        chk("ch3_first_64", 32'(cnt_a), 32'd64);
        wr(4'd3, 8'h40);
        chk("ch3_wrap_period", 32'(period), 32'h1);
        cnt_a = 0;
        for (int i = 0; i < 1024; i++) begin step(1); cnt_a += int'(pwm[3]); end
        chk("ch3_old_64", 32'(cnt_a), 32'd64);
        cnt_a = 0;
        for (int i = 0; i < 1024; i++) begin step(1); cnt_a += int'(pwm[3]); end
        chk("ch3_new_256", 32'(cnt_a), 32'd256);

        // out-of-range writes are ignored
        en = 1'b0;
        for (int a = 12; a < 16; a++) wr(4'(a), 8'hFF);
        step(1);
        en = 1'b1;
        step(1);
        chk("oor_first", 32'(pwm), 32'h009);
        acc = '0;
        for (int i = 0; i < 1023; i++) begin step(1); acc |= pwm; end
        chk("oor_period_or", 32'(acc), 32'h009);
        chk("oor_period", 32'(period), 32'h1);

        // all channels at 0x80, then disable
        for (int c = 0; c < 12; c++) wr(4'(c), 8'h80);
        step(1012);
        chk("all_period", 32'(period), 32'h1);
        step(1);
        chk("all_on", 32'(pwm), 32'hFFF);
        en = 1'b0;
        step(1);
        chk("disable_off", 32'(pwm), 32'h0);

        // asynchronous reset mid-period
        en = 1'b1;
        step(10);
        chk("pre_reset_on", 32'(pwm), 32'hFFF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm), 32'h0);
        chk("async_rst_period", 32'(period), 32'h0);
        step(1);
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 1100; i++) begin step(1); acc |= pwm; end
        chk("post_reset_off", 32'(acc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
